// File: rtl/gcm_ct_unpacker.sv
// Ciphertext block unpacker: buffers 128-bit blocks from aes_api in a FIFO
// and serializes them byte-first with valid/ready, honouring short final blocks.
module gcm_ct_unpacker #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_cp_ready,
    input  logic                    i_cp_last,
    input  logic [4:0]              i_cp_nbytes,
    input  logic [0:127]            i_cipher_text,
    output logic [7:0]              o_byte,
    output logic                    o_byte_valid,
    input  logic                    i_byte_ready,
    output logic                    o_byte_last,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full,
    output logic                    o_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = 128 + 1 + 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [EW-1:0]  mem_q [DEPTH];

    logic [0:0]     state_q,     state_d;
    logic [PW-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [LW-1:0]  level_q,     level_d;
    logic           ovf_q,       ovf_d;
    logic [0:127]   sh_q,        sh_d;
    logic           blast_q,     blast_d;
    logic [4:0]     bcount_q,    bcount_d;
    logic [3:0]     idx_q,       idx_d;
    logic           byte_last_q, byte_last_d;

    logic [4:0]     nb_in;
    logic [EW-1:0]  entry_in;
    logic [EW-1:0]  head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           xfer;
    logic           at_end;
    logic           pop;
    logic           push;

    // Next-state logic for FIFO bookkeeping and the serializer
    always_comb begin
        nb_in       = (!i_cp_last || i_cp_nbytes == 5'd0 || i_cp_nbytes > 5'd16) ? 5'd16 : i_cp_nbytes;
        entry_in    = {i_cipher_text, i_cp_last, nb_in};
        head        = mem_q[rd_ptr_q];
        fifo_empty  = (level_q == LW'(0));
        fifo_full   = (level_q == LW'(DEPTH));
        xfer        = (state_q == SEND) && i_byte_ready;
        at_end      = ({1'b0, idx_q} == (bcount_q - 5'd1));
        pop         = !fifo_empty && ((state_q == IDLE) || (xfer && at_end));
        push        = i_cp_ready && (!fifo_full || pop);

        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        ovf_d       = ovf_q | (i_cp_ready & ~push);
        sh_d        = sh_q;
        blast_d     = blast_q;
        bcount_d    = bcount_q;
        idx_d       = idx_q;
        byte_last_d = byte_last_q;
        level_d     = level_q + LW'(push) - LW'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        // A pop on the final-byte transfer reloads without a bubble
        if (pop) begin
            state_d     = SEND;
            rd_ptr_d    = rd_ptr_q + PW'(1);
            sh_d        = head[EW-1:6];
            blast_d     = head[5];
            bcount_d    = head[4:0];
            idx_d       = 4'd0;
            byte_last_d = head[5] && (head[4:0] == 5'd1);
        end else if (xfer) begin
            if (at_end) begin
                state_d     = IDLE;
                byte_last_d = 1'b0;
            end else begin
                sh_d        = {sh_q[8:127], 8'h00};
                idx_d       = idx_q + 4'd1;
                byte_last_d = blast_q && (({1'b0, idx_q} + 5'd2) == bcount_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            sh_q        <= '0;
            blast_q     <= 1'b0;
            bcount_q    <= 5'd0;
            idx_q       <= 4'd0;
            byte_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            sh_q        <= sh_d;
            blast_q     <= blast_d;
            bcount_q    <= bcount_d;
            idx_q       <= idx_d;
            byte_last_q <= byte_last_d;
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    assign o_byte       = sh_q[0:7];
    assign o_byte_valid = (state_q == SEND);
    assign o_byte_last  = byte_last_q;
    assign o_level      = level_q;
    assign o_full       = fifo_full;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_gcm_ct_unpacker.sv
// Directed bench for gcm_ct_unpacker: ordering, short blocks, backpressure,
// overflow and asynchronous reset against hand-built expected byte streams.
module tb_gcm_ct_unpacker;

    logic           clk;
    logic           reset;
    logic           i_cp_ready;
    logic           i_cp_last;
    logic [4:0]     i_cp_nbytes;
    logic [0:127]   i_cipher_text;
    logic [7:0]     o_byte;
    logic           o_byte_valid;
    logic           i_byte_ready;
    logic           o_byte_last;
    logic [2:0]     o_level;
    logic           o_full;
    logic           o_overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q [$];

    gcm_ct_unpacker #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cp_ready    (i_cp_ready),
        .i_cp_last     (i_cp_last),
        .i_cp_nbytes   (i_cp_nbytes),
        .i_cipher_text (i_cipher_text),
        .o_byte        (o_byte),
        .o_byte_valid  (o_byte_valid),
        .i_byte_ready  (i_byte_ready),
        .o_byte_last   (o_byte_last),
        .o_level       (o_level),
        .o_full        (o_full),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [0:127] mk_block(input logic [7:0] base);
        logic [0:127] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
        return b;
    endfunction

    task automatic queue_bytes(input logic [0:127] blk, input logic last, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({last && (k == n - 1), blk[8*k +: 8]});
    endtask

    // Drive one capture strobe; called and returns at posedge+1
    task automatic push_block(input logic [0:127] blk, input logic last, input logic [4:0] nb);
        i_cp_ready    = 1'b1;
        i_cp_last     = last;
        i_cp_nbytes   = nb;
        i_cipher_text = blk;
        @(posedge clk); #1;
        i_cp_ready    = 1'b0;
        i_cp_last     = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic drain(input int n, input int mode, input int budget);
        int got = 0;
        int cyc = 0;
        int gaps = 0;
        logic started = 1'b0;
        logic stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [8:0] e;
        while (got < n && cyc < budget) begin
            if (mode == 0) i_byte_ready = 1'b1;
            else i_byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (stalled) begin
                check("stall_valid", 32'(o_byte_valid), 32'd1);
                check("stall_hold", 32'(o_byte), 32'(held));
            end
            stalled = 1'b0;
            if (o_byte_valid) begin
                started = 1'b1;
                if (i_byte_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
                    check("byte", 32'(o_byte), 32'(e[7:0]));
                    check("byte_last", 32'(o_byte_last), 32'(e[8]));
                    got++;
                end else begin
                    held = o_byte;
                    stalled = 1'b1;
                end
            end else if (started) begin
                gaps++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_byte_ready = 1'b0;
        check("drain_count", 32'(got), 32'(n));
        check("drain_gaps", 32'(gaps), 32'd0);
    endtask

    initial begin
        logic [7:0]   t1 [16];
        logic [0:127] blk;

        t1 = '{8'h42, 8'h83, 8'h1e, 8'hc2, 8'h21, 8'h77, 8'h74, 8'h24,
               8'h4b, 8'h72, 8'h21, 8'hb7, 8'h84, 8'hd0, 8'hd4, 8'h9c};
        reset = 1'b1;
        i_cp_ready = 1'b0;
        i_cp_last = 1'b0;
        i_cp_nbytes = 5'd0;
        i_cipher_text = '0;
        i_byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte", 32'(o_byte), 32'd0);
        check("rst_valid", 32'(o_byte_valid), 32'd0);
        check("rst_last", 32'(o_byte_last), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single full block with latency check
        for (int k = 0; k < 16; k++) blk[8*k +: 8] = t1[k];
        queue_bytes(blk, 1'b1, 16);
        push_block(blk, 1'b1, 5'd16);
        check("lat_level_e", 32'(o_level), 32'd1);
        check("lat_valid_e", 32'(o_byte_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_e1", 32'(o_byte_valid), 32'd1);
        check("lat_byte0", 32'(o_byte), 32'h42);
        check("lat_level_e1", 32'(o_level), 32'd0);
        drain(16, 0, 40);
        check("t1_idle", 32'(o_byte_valid), 32'd0);

        // Short final block
        blk = mk_block(8'h00);
        queue_bytes(blk, 1'b1, 12);
        push_block(blk, 1'b1, 5'd12);
        drain(12, 0, 40);
        check("short_idle", 32'(o_byte_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("short_no_extra", 32'(o_byte_valid), 32'd0);

        // nbytes=0 on a final block is treated as a full block
        blk = mk_block(8'h50);
        queue_bytes(blk, 1'b1, 16);
        push_block(blk, 1'b1, 5'd0);
        drain(16, 0, 40);

        // Back-to-back blocks
        queue_bytes(mk_block(8'hA0), 1'b0, 16);
        queue_bytes(mk_block(8'hB0), 1'b0, 16);
        queue_bytes(mk_block(8'hC0), 1'b1, 16);
        push_block(mk_block(8'hA0), 1'b0, 5'd3);
        push_block(mk_block(8'hB0), 1'b0, 5'd16);
        push_block(mk_block(8'hC0), 1'b1, 5'd16);
        check("b2b_level_peak", 32'(o_level), 32'd2);
        drain(48, 0, 80);
        check("b2b_level_end", 32'(o_level), 32'd0);

        // Backpressure with ready 1,0,0,1
        blk = mk_block(8'h10);
        queue_bytes(blk, 1'b1, 16);
        push_block(blk, 1'b1, 5'd16);
        drain(16, 1, 100);

        // Overflow: six pushes with ready low
        for (int b = 0; b < 6; b++) begin
            if (b < 5) queue_bytes(mk_block(8'(8'h20 + 8'(b * 16))), b == 4, 16);
            push_block(mk_block(8'(8'h20 + 8'(b * 16))), b >= 4, 5'd16);
        end
        check("ovf_level", 32'(o_level), 32'd4);
        check("ovf_full", 32'(o_full), 32'd1);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_valid", 32'(o_byte_valid), 32'd1);
        drain(80, 0, 120);
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        check("ovf_idle", 32'(o_byte_valid), 32'd0);
        check("ovf_level_end", 32'(o_level), 32'd0);

        // Asynchronous reset after five bytes
        blk = mk_block(8'h60);
        queue_bytes(blk, 1'b1, 16);
        push_block(blk, 1'b1, 5'd16);
        drain(5, 0, 20);
        check("mid_valid_pre", 32'(o_byte_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_byte", 32'(o_byte), 32'd0);
        check("arst_valid", 32'(o_byte_valid), 32'd0);
        check("arst_last", 32'(o_byte_last), 32'd0);
        check("arst_level", 32'(o_level), 32'd0);
        check("arst_full", 32'(o_full), 32'd0);
        check("arst_ovf", 32'(o_overflow), 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        blk = mk_block(8'h70);
        queue_bytes(blk, 1'b1, 16);
        push_block(blk, 1'b1, 5'd16);
        drain(16, 0, 40);
        check("post_rst_ovf", 32'(o_overflow), 32'd0);
        check("post_rst_idle", 32'(o_byte_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
